// File: rtl/battle_ctl.sv
// Battleship game-flow controller: mouse clicks to board cells, ship placement,
// turn alternation over shot/answer/result handshakes, and win/lose detection.
module battle_ctl #(
   parameter int GRID_N    = 10,
   parameter int CELL_LOG2 = 5,
   parameter int OWN_X0    = 96,
   parameter int ENEMY_X0  = 608,
   parameter int GRID_Y0   = 193,
   parameter int SHIPS     = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        mouse_left,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic        start_button,
   input  logic        first_player,
   input  logic        rx_shot_valid,
   input  logic [7:0]  rx_shot_pos,
   output logic        ans_valid,
   output logic        ans_hit,
   output logic        shot_valid,
   output logic [7:0]  shot_pos,
   input  logic        shot_ready,
   input  logic        res_valid,
   input  logic        res_hit,
   output logic [2:0]  state_o,
   output logic [7:0]  cursor_pos,
   output logic [7:0]  ships_left,
   output logic [7:0]  hits,
   output logic        game_over,
   output logic        win,
   output logic        proto_err
);

   // state    | meaning
   // IDLE     | waiting for start_button
   // PLACE    | own-board clicks place ship cells until SHIPS are placed
   // WAIT_OPP | waiting for the opponent's shot, answer it next cycle
   // AIM      | waiting for an enemy-board click on a fresh cell
   // FIRE     | shot_valid held until the link accepts it
   // RESULT   | waiting for the opponent's hit/miss verdict on our shot
   // OVER     | game finished, win tells who won; start restarts
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PLACE    = 3'd1,
      S_WAIT_OPP = 3'd2,
      S_AIM      = 3'd3,
      S_FIRE     = 3'd4,
      S_RESULT   = 3'd5,
      S_OVER     = 3'd6
   } state_t;

   localparam int         CELLS    = GRID_N * GRID_N;
   localparam int         IDX_W    = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam int         BOARD_PX = GRID_N << CELL_LOG2;
   localparam logic [7:0] SHIPS_C  = 8'(SHIPS);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CELLS-1:0]   r_own;
   logic [CELLS-1:0]   r_shot;
   logic               r_mouse_prev;
   logic [7:0]         r_cursor;
   logic [7:0]         r_ships_left;
   logic [7:0]         r_hits;
   logic               r_ans_valid;
   logic               r_ans_hit;
   logic               r_shot_valid;
   logic [7:0]         r_shot_pos;
   logic               r_win;
   logic               r_proto_err;

   logic [12:0]        w_x13;
   logic [12:0]        w_y13;
   logic               w_click;
   logic               w_in_y;
   logic               w_in_own;
   logic               w_in_enemy;
   logic [3:0]         w_row;
   logic [3:0]         w_col;
   logic [IDX_W-1:0]   w_click_idx;
   logic               w_rx_in;
   logic [IDX_W-1:0]   w_rx_idx;
   logic               w_rx_hit;
   logic [IDX_W-1:0]   w_shot_idx;

   logic               w_place;
   logic               w_answer;
   logic               w_load_shot;
   logic               w_fire_ack;
   logic               w_result;
   logic               w_win_now;
   logic               w_restart;
   logic               w_err;

   // Coordinates widened to 13 bits so the board-relative subtraction never wraps.
   assign w_x13      = {1'b0, mouse_xpos};
   assign w_y13      = {1'b0, mouse_ypos};
   assign w_click    = frame_tick & mouse_left & ~r_mouse_prev;
   assign w_in_y     = (w_y13 >= 13'(GRID_Y0)) && (w_y13 < 13'(GRID_Y0 + BOARD_PX));
   assign w_in_own   = w_in_y && (w_x13 >= 13'(OWN_X0)) && (w_x13 < 13'(OWN_X0 + BOARD_PX));
   assign w_in_enemy = w_in_y && (w_x13 >= 13'(ENEMY_X0)) && (w_x13 < 13'(ENEMY_X0 + BOARD_PX));
   assign w_row      = 4'((w_y13 - 13'(GRID_Y0)) >> CELL_LOG2);
   assign w_col      = w_in_own ? 4'((w_x13 - 13'(OWN_X0)) >> CELL_LOG2)
                                : 4'((w_x13 - 13'(ENEMY_X0)) >> CELL_LOG2);
   assign w_click_idx = IDX_W'(32'(w_row) * GRID_N + 32'(w_col));

   assign w_rx_in  = ({1'b0, rx_shot_pos[7:4]} < 5'(GRID_N)) &&
                     ({1'b0, rx_shot_pos[3:0]} < 5'(GRID_N));
   assign w_rx_idx = IDX_W'(32'(rx_shot_pos[7:4]) * GRID_N + 32'(rx_shot_pos[3:0]));
   assign w_rx_hit = w_rx_in && r_own[w_rx_idx];

   assign w_shot_idx = IDX_W'(32'(r_shot_pos[7:4]) * GRID_N + 32'(r_shot_pos[3:0]));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_place     = 1'b0;
      w_answer    = 1'b0;
      w_load_shot = 1'b0;
      w_fire_ack  = 1'b0;
      w_result    = 1'b0;
      w_win_now   = 1'b0;
      w_restart   = 1'b0;
      w_err       = (rx_shot_valid && (r_state != S_WAIT_OPP)) ||
                    (res_valid && (r_state != S_RESULT));
      case (r_state)
         S_IDLE: begin
            if (start_button) w_state_nxt = S_PLACE;
         end
         S_PLACE: begin
            if (r_ships_left >= SHIPS_C)
               w_state_nxt = first_player ? S_AIM : S_WAIT_OPP;
            else if (w_click && w_in_own && !r_own[w_click_idx])
               w_place = 1'b1;
         end
         S_WAIT_OPP: begin
            if (rx_shot_valid) begin
               w_answer = 1'b1;
               if (!w_rx_in) w_err = 1'b1;
               // The answer that sinks our last ship ends the game as a loss.
               w_state_nxt = (w_rx_hit && (r_ships_left <= 8'd1)) ? S_OVER : S_AIM;
            end
         end
         S_AIM: begin
            if (w_click && w_in_enemy && !r_shot[w_click_idx]) begin
               w_load_shot = 1'b1;
               w_state_nxt = S_FIRE;
            end
         end
         S_FIRE: begin
            if (r_shot_valid && shot_ready) begin
               w_fire_ack  = 1'b1;
               w_state_nxt = S_RESULT;
            end
         end
         S_RESULT: begin
            if (res_valid) begin
               w_result    = 1'b1;
               w_win_now   = res_hit && (r_hits >= (SHIPS_C - 8'd1));
               w_state_nxt = w_win_now ? S_OVER : S_WAIT_OPP;
            end
         end
         S_OVER: begin
            if (start_button) begin
               w_restart   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_own        <= '0;
         r_shot       <= '0;
         r_mouse_prev <= 1'b0;
         r_cursor     <= 8'd0;
         r_ships_left <= 8'd0;
         r_hits       <= 8'd0;
         r_ans_valid  <= 1'b0;
         r_ans_hit    <= 1'b0;
         r_shot_valid <= 1'b0;
         r_shot_pos   <= 8'd0;
         r_win        <= 1'b0;
         r_proto_err  <= 1'b0;
      end else begin
         if (frame_tick) r_mouse_prev <= mouse_left;
         if (w_click && (w_in_own || w_in_enemy)) r_cursor <= {w_row, w_col};
         r_ans_valid <= w_answer;
         if (w_answer) r_ans_hit <= w_rx_hit;
         if (w_answer && w_rx_hit) begin
            r_own[w_rx_idx] <= 1'b0;
            if (r_ships_left != 8'd0) r_ships_left <= r_ships_left - 8'd1;
         end
         if (w_place) begin
            r_own[w_click_idx] <= 1'b1;
            if (r_ships_left != 8'hFF) r_ships_left <= r_ships_left + 8'd1;
         end
         if (w_load_shot) begin
            r_shot_valid <= 1'b1;
            r_shot_pos   <= {w_row, w_col};
         end
         if (w_fire_ack) begin
            r_shot_valid       <= 1'b0;
            r_shot[w_shot_idx] <= 1'b1;
         end
         if (w_result && res_hit && (r_hits != 8'hFF)) r_hits <= r_hits + 8'd1;
         if (w_win_now) r_win <= 1'b1;
         if (w_err) r_proto_err <= 1'b1;
         // Restart wins over everything else updated in the same cycle.
         if (w_restart) begin
            r_own        <= '0;
            r_shot       <= '0;
            r_cursor     <= 8'd0;
            r_ships_left <= 8'd0;
            r_hits       <= 8'd0;
            r_ans_hit    <= 1'b0;
            r_shot_pos   <= 8'd0;
            r_win        <= 1'b0;
            r_proto_err  <= 1'b0;
         end
      end
   end

   assign ans_valid  = r_ans_valid;
   assign ans_hit    = r_ans_hit;
   assign shot_valid = r_shot_valid;
   assign shot_pos   = r_shot_pos;
   assign state_o    = r_state;
   assign cursor_pos = r_cursor;
   assign ships_left = r_ships_left;
   assign hits       = r_hits;
   assign game_over  = (r_state == S_OVER);
   assign win        = r_win;
   assign proto_err  = r_proto_err;

endmodule

// File: doc/battle_ctl.md
Name: battle_ctl

Overview:
- Parametrised game-flow controller for the two-player battleship design.
- Converts mouse clicks into grid cells on the own and enemy boards, and records ship placement in an own-board bitmap.
- Alternates turns with the remote player over valid/ready shot and result handshakes, and detects win/lose.
- Sits between the mouse/VGA front end and the inter-board link (UART framer).

Parameters:
GRID_N, 10, cells per board side (2..16)
CELL_LOG2, 5, log2 of cell size in pixels (cell = 32 px)
OWN_X0, 96, left pixel of own board
ENEMY_X0, 608, left pixel of enemy board
GRID_Y0, 193, top pixel of both boards
SHIPS, 10, ship cells to place; hits needed to win (1..GRID_N*GRID_N)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset (0 = reset)
frame_tick  in  1  one-cycle pulse at hcount==0 && vcount==0
mouse_left  in  1  left button level
mouse_xpos  in  12  cursor x, pixels
mouse_ypos  in  12  cursor y, pixels
start_button  in  1  debounced start/restart level
first_player  in  1  1 = this board shoots first
rx_shot_valid  in  1  opponent shot strobe, 1 cycle
rx_shot_pos  in  8  opponent shot {row[7:4],col[3:0]}
ans_valid  out  1  answer strobe to link, 1 cycle
ans_hit  out  1  answer: opponent hit a ship
shot_valid  out  1  own shot request, held until accepted
shot_pos  out  8  own shot {row,col}
shot_ready  in  1  link accepts shot when shot_valid && shot_ready
res_valid  in  1  opponent's result strobe for own shot
res_hit  in  1  result: own shot hit
state_o  out  3  current state encoding
cursor_pos  out  8  last clicked cell {row,col}
ships_left  out  8  own ship cells not yet sunk
hits  out  8  own confirmed hits
game_over  out  1  high in OVER
win  out  1  valid when game_over
proto_err  out  1  sticky: unexpected rx_shot_valid or res_valid

Behaviour:
- Reset (rst==0, async): state IDLE; all outputs 0; both bitmaps cleared; ships_left = 0.
- Click detect: mouse_left sampled only on frame_tick; click = 1 when current sample is 1 and previous sample was 0. At most one click per frame.
- Cell map: the board is own when OWN_X0 <= x < OWN_X0 + (GRID_N << CELL_LOG2); enemy with ENEMY_X0; both use GRID_Y0 for y.
  - col = (x - X0) >> CELL_LOG2; row = (y - GRID_Y0) >> CELL_LOG2.
  - Subtraction is done in 13 bits so no wrap occurs; a click outside either board is ignored.
  - cursor_pos updates on every in-board click.
- States:
  - IDLE (0): start_button==1 -> PLACE.
  - PLACE (1): own-board click on a free cell sets own bit and increments ships_left; clicks on occupied cells or the enemy board are ignored. On the cycle after ships_left reaches SHIPS -> AIM if first_player, else WAIT_OPP.
  - WAIT_OPP (2): on rx_shot_valid, the next cycle pulses ans_valid.
    - ans_hit = own bit at rx_shot_pos; on a hit the bit is cleared and ships_left is decremented.
    - A repeat shot on an already-cleared cell answers miss.
    - rx_shot_pos with row or col >= GRID_N answers miss and sets proto_err.
    - After the answer: ships_left==0 -> OVER (win=0); else -> AIM.
  - AIM (3): enemy-board click on a not-yet-shot cell loads shot_pos and sets shot_valid -> FIRE. Already-shot cells and own-board clicks are ignored.
  - FIRE (4): shot_valid and shot_pos are held stable until shot_ready; on the handshake cycle the shot bit is set, shot_valid drops next cycle -> RESULT.
  - RESULT (5): on res_valid, if res_hit then hits++. hits==SHIPS -> OVER (win=1); else -> WAIT_OPP.
  - OVER (6): game_over=1. start_button==1 clears bitmaps and counters -> IDLE.
- rx_shot_valid outside WAIT_OPP, or res_valid outside RESULT: the strobe is ignored and proto_err is set. proto_err clears only on reset or the OVER->IDLE restart.
- rx_shot_valid in the same cycle as a state entry into WAIT_OPP is accepted.
- Frame-tick gating applies to clicks only; handshakes run every clk.
- Counters are 8 bits and saturate; they cannot exceed SHIPS by construction.
- Unused encoding 7 -> IDLE.

Test Plan:
- Reset: hold rst=0 mid-FIRE with shot_valid=1 -> all outputs 0, state_o=0 immediately (async).
- Place: start=1, then 10 clicks at own cells (x=96+32c+5, y=193+5), one duplicate, one at x=95 -> ships_left=10 only after 10 unique cells; first_player=0 -> state_o=2.
- Answer: rx_shot_pos=8'h00 on a placed cell -> ans_valid 1 cycle later, ans_hit=1, ships_left=9. The same pos again -> ans_hit=0.
- Fire handshake: click enemy (x=608+32*3, y=193+32*2) -> shot_pos=8'h23. shot_ready held low 5 cycles -> shot_valid stays 1 with stable pos; ready=1 -> RESULT. Re-clicking 8'h23 in a later AIM is ignored.
- Win/lose: SHIPS=1 build, res_valid=1, res_hit=1 -> game_over=1, win=1. Separately, last own ship hit -> game_over=1, win=0. start_button -> IDLE with counters cleared.
- Protocol error: res_valid in AIM -> proto_err=1, state unchanged. Double click within one frame -> a single click registered.
